// File: rtl/wb_mem_ctrl.sv
// wb_mem_ctrl: Wishbone slave in front of a word-addressed backing store.
// It adds a first-beat wait latency, single-cycle continuation beats for
// incrementing bursts, and a periodic refresh window that retries new beats.
// Optional feature macro: MEM_RANGE_ERR_EN. When it is defined, out-of-range
// beats terminate with S_ERR. When it is undefined, upper address bits alias
// and S_ERR is never asserted.
module wb_mem_ctrl #(
    parameter int DEPTH_WORDS    = 16384,
    parameter int FIRST_LAT      = 3,
    parameter int REFRESH_PERIOD = 1024,
    parameter int REFRESH_LEN    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        S_STB,
    input  logic        S_CYC,
    input  logic        S_WE,
    input  logic [31:0] S_ADR,
    input  logic [31:0] S_DAT_O,
    output logic [31:0] S_DAT_I,
    input  logic [2:0]  S_CTI_O,
    output logic        S_ACK,
    output logic        S_ERR,
    output logic        S_RTY,
    output logic        refresh_active
);

    localparam int DATA_W = 32;
    localparam int AW     = $clog2(DEPTH_WORDS);
    localparam int WCW    = 4;
    localparam int RLW    = $clog2(REFRESH_LEN) + 1;
    localparam int RPW    = $clog2(REFRESH_PERIOD) + 1;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;

    typedef enum logic [1:0] {IDLE, WAIT, ACK, REFRESH} state_t;

    state_t              state_q, state_d;
    logic [WCW-1:0]      wait_cnt_q;
    logic [RLW-1:0]      ref_len_q;
    logic [RPW-1:0]      ref_cnt_q;
    logic                ref_pend_q;
    logic                rty_q, err_q, burst_q, we_q;
    logic [2:0]          cti_q;
    logic [AW-1:0]       adr_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   mem [DEPTH_WORDS];

    logic                beat, term_busy, first_in, range_bad, adr_unused;
    logic [AW-1:0]       idx_in;
    logic                go_wait, go_ack_idle, go_ack_wait, set_rty, set_err;
    logic                do_write, ref_done;

    assign beat      = S_CYC & S_STB;
    // A beat that was just retried or errored is still on the bus for one
    // cycle; it must not be accepted a second time.
    assign term_busy = rty_q | err_q;
    assign idx_in    = S_ADR[AW+1:2];
    // Only an incrementing beat preceded by an acked incrementing beat is a
    // continuation; classic and constant-address beats always pay the latency.
    assign first_in  = !burst_q || (S_CTI_O == CTI_CLASSIC) || (S_CTI_O == CTI_CONST);

`ifdef MEM_RANGE_ERR_EN
    localparam logic [32:0] RANGE_LIMIT = 33'(DEPTH_WORDS) * 33'd4;
    assign range_bad  = ({1'b0, S_ADR} >= RANGE_LIMIT);
    assign adr_unused = ^S_ADR[1:0];
`else
    assign range_bad  = 1'b0;
    assign adr_unused = ^{S_ADR[31:AW+2], S_ADR[1:0]};
`endif

    assign S_RTY   = rty_q;
    assign S_ERR   = err_q;
    assign S_DAT_I = rdata_q;

    // State register; reset drops any beat in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state decode, termination strobes and status outputs.
    always_comb begin
        state_d        = state_q;
        go_wait        = 1'b0;
        go_ack_idle    = 1'b0;
        go_ack_wait    = 1'b0;
        set_rty        = 1'b0;
        set_err        = 1'b0;
        do_write       = 1'b0;
        ref_done       = 1'b0;
        S_ACK          = (state_q == ACK);
        refresh_active = (state_q == REFRESH);
        case (state_q)
            IDLE: begin
                if (ref_pend_q) begin
                    state_d = REFRESH;
                    set_rty = beat & !term_busy;
                end else if (beat && !term_busy) begin
                    if (range_bad) begin
                        set_err = 1'b1;
                    end else if (first_in) begin
                        state_d = WAIT;
                        go_wait = 1'b1;
                    end else begin
                        state_d     = ACK;
                        go_ack_idle = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (!beat) begin
                    state_d = IDLE;
                end else if (wait_cnt_q == WCW'(FIRST_LAT - 1)) begin
                    state_d     = ACK;
                    go_ack_wait = 1'b1;
                end
            end
            ACK: begin
                state_d  = IDLE;
                do_write = we_q;
            end
            REFRESH: begin
                set_rty = beat & !rty_q;
                if (ref_len_q == RLW'(REFRESH_LEN - 1)) begin
                    state_d  = IDLE;
                    ref_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers: latency counters, refresh timing, burst tracking, read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= '0;
            ref_len_q  <= '0;
            ref_cnt_q  <= '0;
            ref_pend_q <= 1'b0;
            rty_q      <= 1'b0;
            err_q      <= 1'b0;
            burst_q    <= 1'b0;
            we_q       <= 1'b0;
            cti_q      <= CTI_CLASSIC;
            rdata_q    <= '0;
        end else begin
            rty_q <= set_rty;
            err_q <= set_err;

            if (go_wait)                wait_cnt_q <= '0;
            else if (state_q == WAIT)   wait_cnt_q <= wait_cnt_q + 1'b1;

            if (state_q == REFRESH)     ref_len_q <= ref_len_q + 1'b1;
            else                        ref_len_q <= '0;

            if (ref_cnt_q == RPW'(REFRESH_PERIOD - 1)) begin
                ref_cnt_q  <= '0;
                ref_pend_q <= 1'b1;
            end else begin
                ref_cnt_q <= ref_cnt_q + 1'b1;
                if (ref_done) ref_pend_q <= 1'b0;
            end

            if (go_wait || go_ack_idle) begin
                we_q  <= S_WE;
                cti_q <= S_CTI_O;
            end

            if (!S_CYC || set_rty || set_err) burst_q <= 1'b0;
            else if (state_q == ACK)          burst_q <= (cti_q == CTI_INCR);

            if (go_ack_idle && !S_WE)       rdata_q <= mem[idx_in];
            else if (go_ack_wait && !we_q)  rdata_q <= mem[adr_q];
        end
    end

    // Beat address capture; pure datapath, no reset needed.
    always_ff @(posedge clk) begin
        if (go_wait || go_ack_idle) adr_q <= idx_in;
    end

    // Backing store write at the edge that ends the ACK cycle; contents survive reset.
    always_ff @(posedge clk) begin
        if (do_write) mem[adr_q] <= S_DAT_O;
    end

endmodule

// File: doc/wb_mem_ctrl.md
WB_MEM_CTRL -- requirements
Module: wb_mem_ctrl

Interface
REQ-001 SHALL provide parameter DEPTH_WORDS, default 16384: backing store size in 32-bit words; power of two.
REQ-002 SHALL provide parameter FIRST_LAT, default 3: wait cycles before ACK of a first beat; range 1..15.
REQ-003 SHALL provide parameter REFRESH_PERIOD, default 1024: cycles between refresh requests.
REQ-004 SHALL provide parameter REFRESH_LEN, default 4: cycles per refresh window.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have ports S_STB, S_CYC, S_WE, inputs, 1 each: Wishbone strobe, cycle, write enable.
REQ-008 SHALL have port S_ADR, input, 32: byte address; bits [1:0] ignored.
REQ-009 SHALL have port S_DAT_O, input, 32: write data from master.
REQ-010 SHALL have port S_DAT_I, output, 32: read data to master.
REQ-011 SHALL have port S_CTI_O, input, 3: cycle type: 000 classic, 001 constant, 010 incrementing, 111 end of burst.
REQ-012 SHALL have ports S_ACK, S_ERR, S_RTY, outputs, 1 each: termination pulses.
REQ-013 SHALL have port refresh_active, output, 1: high while in REFRESH.

Function
REQ-014 SHALL use FSM states IDLE, WAIT, ACK, REFRESH; a beat is accepted in IDLE when S_CYC & S_STB.
REQ-015 SHALL index memory with S_ADR[log2(DEPTH_WORDS)+1:2].
REQ-016 SHALL treat a beat as first beat unless the previous acked beat in the same S_CYC had CTI 010; CTI 000/001 always first beat.
REQ-017 First beat: IDLE -> WAIT for FIRST_LAT cycles -> ACK; S_ACK high FIRST_LAT+1 cycles after acceptance.
REQ-018 Continuation beat (CTI 010 after 010): IDLE -> ACK; S_ACK high 1 cycle after acceptance.
REQ-019 S_ACK, S_ERR, S_RTY SHALL each be single-cycle pulses, mutually exclusive, one per beat.
REQ-020 Read: S_DAT_I SHALL carry the addressed word in the S_ACK cycle and hold it until the next read ACK.
REQ-021 Write: memory SHALL be updated with S_DAT_O at the clock edge ending the S_ACK cycle.
REQ-022 S_STB or S_CYC low during WAIT SHALL abort: return IDLE, no ACK, no write.
REQ-023 S_CYC low or an acked beat with CTI 111 SHALL clear burst tracking; next beat is a first beat.
REQ-024 A free-running refresh counter SHALL raise refresh_pending at REFRESH_PERIOD-1 and wrap to 0.
REQ-025 Pending refresh SHALL be taken only from IDLE; a beat in WAIT/ACK completes first.
REQ-026 A beat accepted while refresh is pending or active SHALL get S_RTY next cycle, no access, burst tracking cleared; refresh wins over a simultaneous new beat.
REQ-027 REFRESH SHALL last REFRESH_LEN cycles, then return IDLE and clear refresh_pending; counter keeps running.

Reset
REQ-028 rst low SHALL force IDLE, S_ACK/S_ERR/S_RTY/refresh_active 0, S_DAT_I 0, refresh counter 0, burst tracking cleared.
REQ-029 Reset mid-beat SHALL abort without ACK or write; memory contents are not reset.

Configuration
REQ-030 With MEM_RANGE_ERR_EN defined, a beat with S_ADR at or above DEPTH_WORDS*4 SHALL get S_ERR 1 cycle after acceptance, no access, burst tracking cleared.
REQ-031 Without MEM_RANGE_ERR_EN, upper address bits SHALL be ignored (aliasing) and S_ERR tied 0.

Verification
REQ-032 Classic write 0x0000_0010 = 0xDEAD_BEEF, then classic read -> each ACK 4 cycles after acceptance, read returns 0xDEAD_BEEF.
REQ-033 IBC burst of 8 reads from 0x100, STB dropped between beats, last CTI 111 -> first ACK after 4 cycles, remaining after 1 cycle each; next beat pays 4 cycles.
REQ-034 Beat accepted on the cycle refresh_pending rises -> S_RTY pulse, refresh_active high 4 cycles, memory unchanged.
REQ-035 Write beat, S_STB dropped in WAIT cycle 2 -> no ACK, location retains old value.
REQ-036 MEM_RANGE_ERR_EN defined, read 0x0001_0000 -> S_ERR one cycle later; undefined -> ACK with word at 0x0000_0000.
REQ-037 rst low during WAIT of a write -> no ACK, all outputs 0, location unchanged.
